// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// Module  : regfile_pkg
// Brief   : Shared defaults and types for the scoreboarded register file.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

    function automatic int unsigned clog2_aw(input int unsigned n);
        return $clog2(n);
    endfunction

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int PW_DEFAULT   = 2;
    localparam int AW_DEFAULT   = clog2_aw(NREG_DEFAULT);

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] xlen_t;
    typedef logic [PW_DEFAULT-1:0]   pend_t;

endpackage

`default_nettype wire

// File: rtl/sb_counter.sv
//------------------------------------------------------------------------------
// Module  : sb_counter
// Brief   : Saturating pending-write counter for one register (+inc, -dec, floor 0).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sb_counter #(
    parameter int PW = 2,
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic [DW-1:0] dec,
    output logic          full,
    output logic          drained,
    output logic          underflow
);

    localparam int             EW    = ((PW > DW) ? PW : DW) + 1;
    localparam logic [EW-1:0]  c_max = EW'((1 << PW) - 1);

    logic [PW-1:0] r_count;
    logic [EW-1:0] w_cnt;
    logic [EW-1:0] w_dec;
    logic [EW-1:0] w_after;
    logic [EW-1:0] w_next;

    // Decrement floors at zero before the increment is applied.
    always_comb begin
        w_cnt   = EW'(r_count);
        w_dec   = EW'(dec);
        w_after = (w_dec >= w_cnt) ? '0 : (w_cnt - w_dec);
        w_next  = w_after + EW'(inc);
        if (w_next > c_max) begin
            w_next = c_max;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= PW'(w_next);
        end
    end

    assign full      = (w_cnt == c_max);
    assign drained   = (w_after == '0);
    assign underflow = (dec != '0) && (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
//------------------------------------------------------------------------------
// Module  : regfile_scoreboard
// Brief   : Multi-port flop register file with pending-write scoreboard and bypass.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int NREG    = NREG_DEFAULT,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int PW      = PW_DEFAULT,
    parameter int ZERO_R0 = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NRD*clog2_aw(NREG)-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]          rd_data,
    output logic [NRD-1:0]               rd_ready,
    input  logic                         alloc_valid,
    input  logic [clog2_aw(NREG)-1:0]    alloc_addr,
    output logic                         alloc_ready,
    input  logic [NWR-1:0]               wr_en,
    input  logic [NWR*clog2_aw(NREG)-1:0] wr_addr,
    input  logic [NWR*XLEN-1:0]          wr_data,
    output logic                         sb_err
);

    localparam int AW = clog2_aw(NREG);
    localparam int DW = $clog2(NWR + 1);

    logic [XLEN-1:0]          r_regs [NREG];
    logic                     r_sb_err;
    logic [NREG-1:0][DW-1:0]  w_dec_raw;
    logic [NREG-1:0][DW-1:0]  w_dec;
    logic [NREG-1:0]          w_inc;
    logic [NREG-1:0]          w_full;
    logic [NREG-1:0]          w_drained;
    logic [NREG-1:0]          w_underflow;
    logic                     w_alloc_fire;

    // Per-register writeback hit count; register 0 is inert when hardwired.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_dec_raw[r] = '0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
                    w_dec_raw[r] = w_dec_raw[r] + DW'(1);
                end
            end
            w_dec[r] = (ZERO_R0 != 0 && r == 0) ? '0 : w_dec_raw[r];
            w_inc[r] = w_alloc_fire && (alloc_addr == AW'(r)) && !(ZERO_R0 != 0 && r == 0);
        end
    end

    assign alloc_ready  = !(w_full[alloc_addr] && (w_dec_raw[alloc_addr] == '0));
    assign w_alloc_fire = alloc_valid && alloc_ready;

    for (genvar r = 0; r < NREG; r++) begin : g_pend
        sb_counter #(
            .PW (PW),
            .DW (DW)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (w_inc[r]),
            .dec       (w_dec[r]),
            .full      (w_full[r]),
            .drained   (w_drained[r]),
            .underflow (w_underflow[r])
        );
    end

    // Later ports are applied last so the highest index wins on a collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && !(ZERO_R0 != 0 && wr_addr[j*AW +: AW] == '0)) begin
                    r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sb_err <= 1'b0;
        end else if (|w_underflow) begin
            r_sb_err <= 1'b1;
        end
    end

    assign sb_err = r_sb_err;

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0]   v_addr;
            logic [XLEN-1:0] v_data;
            v_addr = rd_addr[i*AW +: AW];
            v_data = r_regs[v_addr];
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == v_addr)) begin
                    v_data = wr_data[j*XLEN +: XLEN];
                end
            end
            if ((ZERO_R0 != 0 && v_addr == '0) || !reset) begin
                v_data = '0;
            end
            rd_data[i*XLEN +: XLEN] = v_data;
            rd_ready[i]             = w_drained[v_addr];
        end
    end

endmodule

`default_nettype wire
